rc_filter_bank_scheduler: RTL and testbench

RC_FILTER_BANK_SCHEDULER -- requirements
Module: rc_filter_bank_scheduler

---
 rtl/rc_filter_bank_scheduler.sv | 158 +++++++++++++++
 tb/tb_rc_filter_bank_scheduler.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/rc_filter_bank_scheduler.sv
// Time-multiplexed bank of first-order RC low-pass filters: one shared update engine
// walks every channel STEPS times per audio tick. Optional leak: `RC_FILTER_SCHED_LEAK_EN.
module rc_filter_bank_scheduler #(
  parameter int CHANNELS = 4,
  parameter int STEPS    = 16,
  parameter int LEAK_16  = 65535 - (65535 / STEPS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    audio_clk_en,
  input  logic [16*CHANNELS-1:0]  in,
  input  logic [16*CHANNELS-1:0]  alpha,
  output logic [16*CHANNELS-1:0]  out,
  output logic                    busy,
  output logic                    done,
  output logic                    overrun
);

  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int ST_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  state_q;
  logic [CH_W-1:0]         ch_q;
  logic [ST_W-1:0]         step_q;
  logic signed [15:0]      y_q      [CHANNELS];
  logic signed [15:0]      in_lat_q [CHANNELS];
  logic [15:0]             alpha_lat_q [CHANNELS];
  logic [16*CHANNELS-1:0]  out_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    overrun_q;

  // Shared datapath: operands of the channel currently being updated.
  logic signed [15:0]      y_cur;
  logic signed [15:0]      x_cur;
  logic [15:0]             a_cur;
  logic signed [16:0]      diff;
  logic signed [33:0]      prod;
  logic signed [17:0]      prod_sh;
  logic signed [18:0]      sum;
  logic signed [15:0]      y_sat;
  logic [16*CHANNELS-1:0]  out_d;
  logic                    last_step;
  logic                    last_ch;

  assign y_cur   = y_q[ch_q];
  assign x_cur   = in_lat_q[ch_q];
  assign a_cur   = alpha_lat_q[ch_q];
  assign diff    = {x_cur[15], x_cur} - {y_cur[15], y_cur};
  assign prod    = $signed({1'b0, a_cur}) * diff;
  // Taking the upper bits of a two's-complement product is a flooring >>> 16.
  assign prod_sh = prod[33:16];

`ifdef RC_FILTER_SCHED_LEAK_EN
  localparam logic [15:0] LEAK_W = LEAK_16[15:0];
  logic signed [32:0] leak_prod;
  logic signed [16:0] leak_sh;

  assign leak_prod = $signed({1'b0, LEAK_W}) * y_cur;
  assign leak_sh   = leak_prod[32:16];
  assign sum       = {{2{leak_sh[16]}}, leak_sh} + {prod_sh[17], prod_sh};
`else
  assign sum       = {{3{y_cur[15]}}, y_cur} + {prod_sh[17], prod_sh};
`endif

  always_comb begin
    y_sat = sum[15:0];
    if (sum[18:15] != 4'b0000 && sum[18:15] != 4'b1111) begin
      y_sat = sum[18] ? 16'sh8000 : 16'sh7FFF;
    end
  end

  assign last_step = (step_q == ST_W'(STEPS - 1));
  assign last_ch   = (ch_q == CH_W'(CHANNELS - 1));

  // Output snapshot taken on the final update edge, so the last channel's
  // fresh result is forwarded instead of its stale stored value.
  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_out
      assign out_d[16*gi +: 16] = (ch_q == CH_W'(gi)) ? y_sat : y_q[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ch_q      <= '0;
      step_q    <= '0;
      out_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
        y_q[k]         <= '0;
        in_lat_q[k]    <= '0;
        alpha_lat_q[k] <= '0;
      end
    end else begin
      if (audio_clk_en && state_q != S_IDLE) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (audio_clk_en) begin
            for (int k = 0; k < CHANNELS; k++) begin
              in_lat_q[k]    <= in[16*k +: 16];
              alpha_lat_q[k] <= alpha[16*k +: 16];
            end
            ch_q    <= '0;
            step_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          y_q[ch_q] <= y_sat;
          if (last_step) begin
            step_q <= '0;
            if (last_ch) begin
              ch_q    <= '0;
              out_q   <= out_d;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              ch_q <= ch_q + 1'b1;
            end
          end else begin
            step_q <= step_q + 1'b1;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign out     = out_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_rc_filter_bank_scheduler.sv
// Directed bench for rc_filter_bank_scheduler with CHANNELS=2, STEPS=4 (leak disabled).
module tb_rc_filter_bank_scheduler;

  localparam int CH = 2;
  localparam int ST = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          tick;
  logic [31:0]   in_v;
  logic [31:0]   alpha_v;
  logic [31:0]   out_v;
  logic          busy;
  logic          done;
  logic          overrun;

  int n_tests = 0;
  int n_fail  = 0;
  int lat;
  int y0s [4];
  int y1s [4];

  always #5 clk = ~clk;

  rc_filter_bank_scheduler #(.CHANNELS(CH), .STEPS(ST)) dut (
    .clk          (clk),
    .reset        (reset),
    .audio_clk_en (tick),
    .in           (in_v),
    .alpha        (alpha_v),
    .out          (out_v),
    .busy         (busy),
    .done         (done),
    .overrun      (overrun)
  );

  task automatic check_val(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: %0d", tag, got);
    end
  endtask

  function automatic int out_ch(input int k);
    logic signed [15:0] v;
    v = out_v[16*k +: 16];
    return int'(v);
  endfunction

  // Caller is #1 after a rising edge. Returns the edge count at which done was
  // first seen (0 if never within the budget) and captures per-step y values.
  task automatic run_frame(input int inject_at, input int reset_at);
    lat  = 0;
    tick = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk);
      #1;
      if (e == 1) tick = 1'b0;
      if (e >= 2 && e <= 5) y0s[e-2] = int'(dut.y_q[0]);
      if (e >= 6 && e <= 9) y1s[e-6] = int'(dut.y_q[1]);
      if (done && lat == 0) lat = e;
      if (e == inject_at) begin
        tick = 1'b1;
        in_v[15:0] = 16'd5000;
      end
      if (e == inject_at + 1) tick = 1'b0;
      if (e == reset_at) reset = 1'b1;
      if (e == reset_at + 1) reset = 1'b0;
      if (lat != 0) break;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check_val("rst_async_out0", out_ch(0), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic set_inputs(input int i0, input int a0, input int i1, input int a1);
    in_v[15:0]     = i0[15:0];
    alpha_v[15:0]  = a0[15:0];
    in_v[31:16]    = i1[15:0];
    alpha_v[31:16] = a1[15:0];
  endtask

  task automatic check_after_done(input string tag);
    check_val({tag, "_done_pulse"}, int'(done), 1);
    @(posedge clk);
    #1;
    check_val({tag, "_done_clear"}, int'(done), 0);
    check_val({tag, "_busy_clear"}, int'(busy), 0);
  endtask

  int exp0 [4];
  int exp1 [4];

  initial begin
    reset   = 1'b1;
    tick    = 1'b0;
    in_v    = '0;
    alpha_v = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_val("reset_out", int'(out_v), 0);
    check_val("reset_busy", int'(busy), 0);
    check_val("reset_done", int'(done), 0);
    check_val("reset_overrun", int'(overrun), 0);

    // Frame A: +1000 and -1000 at alpha=0.5 on both channels.
    set_inputs(1000, 32768, -1000, 32768);
    exp0 = '{500, 750, 875, 937};
    exp1 = '{-500, -750, -875, -938};
    run_frame(-10, -10);
    check_val("A_latency", lat, 9);
    for (int s = 0; s < 4; s++) begin
      check_val($sformatf("A_y0_step%0d", s), y0s[s], exp0[s]);
      check_val($sformatf("A_y1_step%0d", s), y1s[s], exp1[s]);
    end
    check_val("A_out0", out_ch(0), 937);
    check_val("A_out1", out_ch(1), -938);
    check_val("A_busy_in_done", int'(busy), 1);
    check_after_done("A");
    check_val("A_overrun", int'(overrun), 0);

    // Frame B1: ch0 frozen by alpha=0, ch1 driven to full-scale negative.
    @(posedge clk);
    #1;
    set_inputs(20000, 0, -32768, 65535);
    run_frame(-10, -10);
    check_val("B1_latency", lat, 9);
    check_val("B1_out0_alpha0", out_ch(0), 937);
    check_val("B1_out1", out_ch(1), -32768);
    check_after_done("B1");

    // Frame B2: from -32768 toward +32767 at alpha=65535.
    @(posedge clk);
    #1;
    set_inputs(20000, 0, 32767, 65535);
    run_frame(-10, -10);
    check_val("B2_y1_first", y1s[0], 32766);
    check_val("B2_out0_alpha0", out_ch(0), 937);
    check_val("B2_out1", out_ch(1), 32766);
    check_after_done("B2");
    check_val("B2_overrun", int'(overrun), 0);

    // Overrun: extra tick with new inputs mid-frame must be ignored.
    do_reset();
    set_inputs(1000, 32768, -1000, 32768);
    run_frame(3, -10);
    check_val("OV_latency", lat, 9);
    check_val("OV_out0", out_ch(0), 937);
    check_val("OV_out1", out_ch(1), -938);
    check_val("OV_flag", int'(overrun), 1);
    check_after_done("OV");
    @(posedge clk);
    #1;
    set_inputs(1000, 0, -1000, 0);
    run_frame(-10, -10);
    check_val("OV_sticky", int'(overrun), 1);
    check_val("OV_hold_out0", out_ch(0), 937);
    check_after_done("OV2");

    // Reset mid-frame: no partial result, done never pulses.
    do_reset();
    check_val("RST_overrun_clear", int'(overrun), 0);
    set_inputs(1000, 32768, -1000, 32768);
    run_frame(-10, 5);
    check_val("RST_no_done", lat, 0);
    check_val("RST_out", int'(out_v), 0);
    check_val("RST_busy", int'(busy), 0);
    run_frame(-10, -10);
    check_val("RST_full_latency", lat, 9);
    check_val("RST_full_out0", out_ch(0), 937);
    check_val("RST_full_out1", out_ch(1), -938);
    check_after_done("RST");

    // Tick in the first idle cycle after DONE starts a normal frame.
    set_inputs(20000, 0, -32768, 65535);
    run_frame(-10, -10);
    check_val("B2B_latency", lat, 9);
    check_val("B2B_out0", out_ch(0), 937);
    check_val("B2B_out1", out_ch(1), -32768);
    check_val("B2B_overrun", int'(overrun), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
